// File: rtl/lcd_rgb_ctrl_if.sv
// lcd_rgb_ctrl_if: pad, pixel-source and panel-ID signals of the LCD RGB controller
interface lcd_rgb_ctrl_if;
  logic [23:0] lcd_rgb_i;
  logic [23:0] pix_data;
  logic        pix_de;
  logic [23:0] lcd_rgb_o;
  logic        lcd_rgb_oe;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_err;
  logic        pix_en;
  modport master (
    output lcd_rgb_i, pix_data, pix_de,
    input  lcd_rgb_o, lcd_rgb_oe, lcd_id, id_valid, id_err, pix_en
  );
  modport slave (
    input  lcd_rgb_i, pix_data, pix_de,
    output lcd_rgb_o, lcd_rgb_oe, lcd_id, id_valid, id_err, pix_en
  );
endinterface

// File: rtl/lcd_rgb_ctrl.sv
// lcd_rgb_ctrl: reads panel ID straps off the released RGB bus, then drives pixels
module lcd_rgb_ctrl #(
  parameter int          ID_WAIT    = 16,
  parameter int          SAMPLES    = 3,
  parameter int          MAX_RETRY  = 3,
  parameter logic [15:0] ID_DEFAULT = 16'd5
) (
  input logic           clk,
  input logic           rst,
  lcd_rgb_ctrl_if.slave bus
);
  localparam int RW = MAX_RETRY > 1 ? $clog2(MAX_RETRY) : 1;
  typedef enum logic [1:0] {SETTLE, SAMPLE, TURN, RUN} state_t;
  state_t state, next;
  logic [9:0] wait_cnt;
  logic [3:0] smp_cnt;
  logic [RW-1:0] retry;
  logic [2:0] word, ref_word;
  logic mis_q, settle_done, last, mis, fall, accept;
  logic [23:0] rgb_q, rgb_d;
  logic [15:0] id_q, id_d;
  logic oe_q, oe_d, pix_en_q, pix_en_d, valid_q, valid_d, err_q, err_d;
  assign word        = {bus.lcd_rgb_i[7], bus.lcd_rgb_i[15], bus.lcd_rgb_i[23]};
  assign settle_done = wait_cnt == 10'(ID_WAIT - 1);
  assign last        = smp_cnt == 4'(SAMPLES - 1);
  // the round is judged only after all samples, so a mismatch is remembered until then
  assign mis         = mis_q | (smp_cnt != 4'd0 && word != ref_word);
  assign fall        = retry == RW'(MAX_RETRY - 1);
  assign accept      = state == SAMPLE && last && (!mis || fall);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SETTLE;
    else state <= next;
  always_comb
    case (state)
      SETTLE:  next = settle_done ? SAMPLE : SETTLE;
      SAMPLE:  next = !last ? SAMPLE : accept ? TURN : SETTLE;
      default: next = RUN;
    endcase
  always_comb begin
    rgb_d    = state == RUN && bus.pix_de ? bus.pix_data : 24'h0;
    oe_d     = next == RUN;
    pix_en_d = next == RUN;
    id_d     = accept ? (mis ? ID_DEFAULT : {13'b0, word}) : id_q;
    valid_d  = accept | valid_q;
    err_d    = accept ? mis : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_cnt <= '0;
      smp_cnt  <= '0;
      retry    <= '0;
      ref_word <= '0;
      mis_q    <= 1'b0;
      rgb_q    <= '0;
      oe_q     <= 1'b0;
      pix_en_q <= 1'b0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= state == SETTLE && !settle_done ? wait_cnt + 10'd1 : '0;
      smp_cnt  <= state == SAMPLE && !last ? smp_cnt + 4'd1 : '0;
      ref_word <= state == SAMPLE && smp_cnt == 4'd0 ? word : ref_word;
      mis_q    <= state == SAMPLE && !last ? mis : 1'b0;
      retry    <= state == SAMPLE && last && !accept ? retry + 1'b1 : retry;
      rgb_q    <= rgb_d;
      oe_q     <= oe_d;
      pix_en_q <= pix_en_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  assign bus.lcd_rgb_o  = rgb_q;
  assign bus.lcd_rgb_oe = oe_q;
  assign bus.pix_en     = pix_en_q;
  assign bus.lcd_id     = id_q;
  assign bus.id_valid   = valid_q;
  assign bus.id_err     = err_q;
endmodule

// File: tb/tb_lcd_rgb_ctrl.sv
// tb_lcd_rgb_ctrl: strap-ID resolution, retry/fallback timing, pixel path and async reset
module tb_lcd_rgb_ctrl;
  localparam int          ID_WAIT    = 16;
  localparam int          SAMPLES    = 3;
  localparam int          MAX_RETRY  = 3;
  localparam logic [15:0] ID_DEFAULT = 16'd5;
  localparam int          ROUND      = ID_WAIT + SAMPLES;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  logic [15:0] exp_id;
  lcd_rgb_ctrl_if bus();
  lcd_rgb_ctrl #(.ID_WAIT(ID_WAIT), .SAMPLES(SAMPLES), .MAX_RETRY(MAX_RETRY), .ID_DEFAULT(ID_DEFAULT))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_oe"}, 32'(bus.lcd_rgb_oe), 0);
    chk({tag, "_pix_en"}, 32'(bus.pix_en), 0);
    chk({tag, "_id_valid"}, 32'(bus.id_valid), 0);
    chk({tag, "_id_err"}, 32'(bus.id_err), 0);
    chk({tag, "_lcd_id"}, 32'(bus.lcd_id), 0);
    chk({tag, "_rgb_o"}, 32'(bus.lcd_rgb_o), 0);
  endtask
  // k = number of rounds whose 2nd sample disagrees; s = {bit7, bit15, bit23} strap value
  task automatic id_phase(input int k, input logic [2:0] s);
    int rounds, en;
    logic eerr;
    logic [23:0] v;
    rounds = k >= MAX_RETRY ? MAX_RETRY : k + 1;
    en     = rounds * ROUND;
    eerr   = k >= MAX_RETRY;
    exp_id = eerr ? ID_DEFAULT : {13'b0, s};
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= en + 4; n++) begin
      v = 24'($urandom);
      v[7] = s[2];
      v[15] = s[1];
      v[23] = s[0];
      if ((n - 1) / ROUND < k && (n - 1) % ROUND == ID_WAIT + 1) v[7] = ~v[7];
      bus.lcd_rgb_i = v;
      bus.pix_de    = 1'($urandom);
      bus.pix_data  = 24'($urandom);
      @(posedge clk);
      #1;
      chk("id_valid", 32'(bus.id_valid), 32'(n >= en));
      chk("oe", 32'(bus.lcd_rgb_oe), 32'(n > en));
      chk("pix_en", 32'(bus.pix_en), 32'(n > en));
      if (n <= en + 1) chk("rgb_o_idle", 32'(bus.lcd_rgb_o), 0);
      if (n >= en) begin
        chk("lcd_id", 32'(bus.lcd_id), 32'(exp_id));
        chk("id_err", 32'(bus.id_err), 32'(eerr));
      end
      @(negedge clk);
    end
  endtask
  task automatic run_phase(input int cycles);
    logic [23:0] d;
    logic de;
    for (int c = 0; c < cycles; c++) begin
      d  = c < 2 ? 24'hA5C3F0 : 24'($urandom);
      de = c == 0 ? 1'b1 : c == 1 ? 1'b0 : 1'($urandom);
      bus.pix_data  = d;
      bus.pix_de    = de;
      bus.lcd_rgb_i = 24'($urandom);
      @(posedge clk);
      #1;
      chk("rgb_o", 32'(bus.lcd_rgb_o), 32'(de ? d : 24'h0));
      chk("run_lcd_id", 32'(bus.lcd_id), 32'(exp_id));
      chk("run_oe", 32'(bus.lcd_rgb_oe), 1);
      @(negedge clk);
    end
  endtask
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
  endtask
  initial begin
    bus.lcd_rgb_i = '0;
    bus.pix_data  = '0;
    bus.pix_de    = 1'b0;
    #2;
    chk_reset_state("reset");
    id_phase(0, 3'b101);
    run_phase(12);
    pulse_rst();
    id_phase(1, 3'b110);
    run_phase(8);
    pulse_rst();
    id_phase(3, 3'b101);
    run_phase(8);
    for (int i = 0; i < 4; i++) begin
      pulse_rst();
      id_phase(int'($urandom_range(0, 4)), 3'($urandom));
      run_phase(6);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
